// File: rtl/datapath_pipe.sv
// Pipelined register-file/ALU datapath: one command per cycle and a single-entry output stage.
// A result is visible the cycle after acceptance; it commits to the registers and flags when consumed.
module datapath_pipe #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              mux_sel,
  input  logic              write_enable,
  input  logic [WIDTH-1:0]  input_data,
  input  logic [ADDR_W-1:0] dst_sel,
  input  logic [ADDR_W-1:0] a_sel,
  input  logic [ADDR_W-1:0] b_sel,
  input  logic [3:0]        op_sel,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_data,
  output logic [ADDR_W-1:0] res_dst,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_n
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic              res_valid_q, res_valid_d;
  logic [WIDTH-1:0]  res_data_q, res_data_d;
  logic [ADDR_W-1:0] res_dst_q, res_dst_d;
  logic              res_we_q, res_we_d;
  logic              pend_z_q, pend_z_d;
  logic              pend_c_q, pend_c_d;
  logic              pend_n_q, pend_n_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_n_q, flag_n_d;

  logic              accept, drain;
  logic              fwd_a, fwd_b, c_in;
  logic [WIDTH-1:0]  opa, opb, alu_res, x_res;
  logic [WIDTH:0]    sum;
  logic              alu_c, x_c, x_z, x_n;

  assign cmd_ready = !res_valid_q || res_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign drain     = res_valid_q && res_ready;

  // The W entry is the newest value of its destination, so it overrides the register file.
  assign fwd_a = res_valid_q && res_we_q && (res_dst_q == a_sel);
  assign fwd_b = res_valid_q && res_we_q && (res_dst_q == b_sel);
  assign opa   = fwd_a ? res_data_q : regs_q[a_sel];
  assign opb   = fwd_b ? res_data_q : regs_q[b_sel];
  assign c_in  = res_valid_q ? pend_c_q : flag_c_q;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    sum     = '0;
    case (op_sel)
      4'd0: begin
        sum     = {1'b0, opa} + {1'b0, opb};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      4'd1: begin
        alu_res = opa - opb;
        alu_c   = (opa < opb);
      end
      4'd2: alu_res = opa & opb;
      4'd3: alu_res = opa | opb;
      4'd4: alu_res = opa ^ opb;
      4'd5: alu_res = ~opa;
      4'd6: begin
        alu_res = {opa[WIDTH-2:0], 1'b0};
        alu_c   = opa[WIDTH-1];
      end
      4'd7: begin
        alu_res = {1'b0, opa[WIDTH-1:1]};
        alu_c   = opa[0];
      end
      4'd8: alu_res = opa;
      4'd9: alu_res = opb;
      4'd10: begin
        sum     = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, c_in};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      default: ;
    endcase
  end

  always_comb begin
    x_res = mux_sel ? input_data : alu_res;
    x_c   = mux_sel ? 1'b0 : alu_c;
    x_z   = (x_res == '0);
    x_n   = x_res[WIDTH-1];
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_dst_d   = res_dst_q;
    res_we_d    = res_we_q;
    pend_z_d    = pend_z_q;
    pend_c_d    = pend_c_q;
    pend_n_d    = pend_n_q;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    flag_n_d    = flag_n_q;
    regs_d      = regs_q;
    if (drain) begin
      res_valid_d = 1'b0;
      flag_z_d    = pend_z_q;
      flag_c_d    = pend_c_q;
      flag_n_d    = pend_n_q;
      if (res_we_q) regs_d[res_dst_q] = res_data_q;
    end
    if (accept) begin
      res_valid_d = 1'b1;
      res_data_d  = x_res;
      res_dst_d   = dst_sel;
      res_we_d    = write_enable;
      pend_z_d    = x_z;
      pend_c_d    = x_c;
      pend_n_d    = x_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_dst_q   <= '0;
      res_we_q    <= 1'b0;
      pend_z_q    <= 1'b0;
      pend_c_q    <= 1'b0;
      pend_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_dst_q   <= res_dst_d;
      res_we_q    <= res_we_d;
      pend_z_q    <= pend_z_d;
      pend_c_q    <= pend_c_d;
      pend_n_q    <= pend_n_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      flag_n_q    <= flag_n_d;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_dst   = res_dst_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign flag_n    = flag_n_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe: an 8-bit/16-register instance and a 16-bit/8-register instance.
module tb_datapath_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // 8-bit instance
  logic       rst_n, cmd_valid, cmd_ready, mux_sel, write_enable;
  logic [7:0] input_data, res_data;
  logic [3:0] dst_sel, a_sel, b_sel, op_sel, res_dst;
  logic       res_valid, res_ready, flag_z, flag_c, flag_n;

  // 16-bit instance
  logic        rst_n16, cmd_valid16, cmd_ready16, mux_sel16, write_enable16;
  logic [15:0] input_data16, res_data16;
  logic [2:0]  dst_sel16, a_sel16, b_sel16, res_dst16;
  logic [3:0]  op_sel16;
  logic        res_valid16, res_ready16, flag_z16, flag_c16, flag_n16;

  datapath_pipe #(.WIDTH(8), .ADDR_W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .mux_sel(mux_sel), .write_enable(write_enable), .input_data(input_data),
    .dst_sel(dst_sel), .a_sel(a_sel), .b_sel(b_sel), .op_sel(op_sel),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_dst(res_dst),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n)
  );

  datapath_pipe #(.WIDTH(16), .ADDR_W(3)) u16 (
    .clk(clk), .rst_n(rst_n16), .cmd_valid(cmd_valid16), .cmd_ready(cmd_ready16),
    .mux_sel(mux_sel16), .write_enable(write_enable16), .input_data(input_data16),
    .dst_sel(dst_sel16), .a_sel(a_sel16), .b_sel(b_sel16), .op_sel(op_sel16),
    .res_valid(res_valid16), .res_ready(res_ready16), .res_data(res_data16), .res_dst(res_dst16),
    .flag_z(flag_z16), .flag_c(flag_c16), .flag_n(flag_n16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cmd8(input logic mux, input logic we, input logic [3:0] dst,
                      input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                      input logic [7:0] data);
    cmd_valid = 1'b1; mux_sel = mux; write_enable = we; dst_sel = dst;
    a_sel = a; b_sel = b; op_sel = op; input_data = data;
  endtask

  task automatic cmd16(input logic mux, input logic we, input logic [2:0] dst,
                       input logic [2:0] a, input logic [2:0] b, input logic [3:0] op,
                       input logic [15:0] data);
    cmd_valid16 = 1'b1; mux_sel16 = mux; write_enable16 = we; dst_sel16 = dst;
    a_sel16 = a; b_sel16 = b; op_sel16 = op; input_data16 = data;
  endtask

  task automatic flags8(input string tag, input logic z, input logic c, input logic n);
    chk({tag, "_z"}, {31'd0, flag_z}, {31'd0, z});
    chk({tag, "_c"}, {31'd0, flag_c}, {31'd0, c});
    chk({tag, "_n"}, {31'd0, flag_n}, {31'd0, n});
  endtask

  initial begin
    rst_n = 1'b1; rst_n16 = 1'b1;
    res_ready = 1'b1; res_ready16 = 1'b1;
    cmd8(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00);
    cmd_valid = 1'b0;
    cmd16(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0000);
    cmd_valid16 = 1'b0;
    #2;
    rst_n = 1'b0; rst_n16 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_data", {24'd0, res_data}, 32'h00);
    chk("rst_dst", {28'd0, res_dst}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    flags8("rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; rst_n16 = 1'b1;
    cyc();

    // Loads
    cmd8(1'b1, 1'b1, 4'd1, 4'd0, 4'd0, 4'd0, 8'h05); cyc();
    chk("ld1_valid", {31'd0, res_valid}, 32'd1);
    chk("ld1_data", {24'd0, res_data}, 32'h05);
    chk("ld1_dst", {28'd0, res_dst}, 32'd1);
    cmd8(1'b1, 1'b1, 4'd2, 4'd0, 4'd0, 4'd0, 8'h03); cyc();
    chk("ld2_data", {24'd0, res_data}, 32'h03);
    flags8("ld1", 1'b0, 1'b0, 1'b0);

    // Forwarded SUB then ADD, back to back
    cmd8(1'b0, 1'b1, 4'd3, 4'd2, 4'd1, 4'd1, 8'h00); cyc();
    chk("sub_data", {24'd0, res_data}, 32'hFE);
    cmd8(1'b0, 1'b1, 4'd4, 4'd3, 4'd1, 4'd0, 8'h00); cyc();
    chk("add_data", {24'd0, res_data}, 32'h03);
    flags8("sub", 1'b0, 1'b1, 1'b1);

    // ADD with carry-out then ADC consuming the pending carry
    cmd8(1'b1, 1'b1, 4'd7, 4'd0, 4'd0, 4'd0, 8'hFF); cyc();
    cmd8(1'b1, 1'b1, 4'd8, 4'd0, 4'd0, 4'd0, 8'h01); cyc();
    cmd8(1'b0, 1'b1, 4'd5, 4'd7, 4'd8, 4'd0, 8'h00); cyc();
    chk("addc_data", {24'd0, res_data}, 32'h00);
    flags8("ld8", 1'b0, 1'b0, 1'b0);
    cmd8(1'b0, 1'b1, 4'd6, 4'd0, 4'd0, 4'd10, 8'h00); cyc();
    chk("adc_data", {24'd0, res_data}, 32'h01);
    flags8("addc", 1'b1, 1'b1, 1'b0);

    // Backpressure: ADC entry for R6 held, next command forwards from it on release
    res_ready = 1'b0;
    cmd8(1'b0, 1'b1, 4'd9, 4'd6, 4'd1, 4'd0, 8'h00);
    #1;
    chk("bp_ready", {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_data", {24'd0, res_data}, 32'h01);
      chk("bp_dst", {28'd0, res_dst}, 32'd6);
      chk("bp_ready_hold", {31'd0, cmd_ready}, 32'd0);
      flags8("bp_frozen", 1'b1, 1'b1, 1'b0);
    end
    res_ready = 1'b1; cyc();
    chk("rel_data", {24'd0, res_data}, 32'h06);
    chk("rel_dst", {28'd0, res_dst}, 32'd9);
    flags8("adc", 1'b0, 1'b0, 1'b0);
    cmd8(1'b0, 1'b0, 4'd6, 4'd6, 4'd0, 4'd8, 8'h00); cyc();
    chk("r6_read", {24'd0, res_data}, 32'h01);

    // Shifts without write
    cmd8(1'b1, 1'b1, 4'd10, 4'd0, 4'd0, 4'd0, 8'h81); cyc();
    cmd8(1'b0, 1'b0, 4'd10, 4'd10, 4'd0, 4'd6, 8'h00); cyc();
    chk("shl_data", {24'd0, res_data}, 32'h02);
    cmd8(1'b0, 1'b0, 4'd0, 4'd10, 4'd0, 4'd8, 8'h00); cyc();
    chk("shl_nowrite", {24'd0, res_data}, 32'h81);
    flags8("shl", 1'b0, 1'b1, 1'b0);
    cmd8(1'b0, 1'b0, 4'd0, 4'd8, 4'd0, 4'd7, 8'h00); cyc();
    chk("shr_data", {24'd0, res_data}, 32'h00);
    flags8("pass81", 1'b0, 1'b0, 1'b1);
    cmd8(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd5, 8'h00); cyc();
    chk("not_data", {24'd0, res_data}, 32'hFF);
    flags8("shr", 1'b1, 1'b1, 1'b0);
    cmd8(1'b0, 1'b0, 4'd0, 4'd7, 4'd8, 4'd12, 8'h00); cyc();
    chk("op12_data", {24'd0, res_data}, 32'h00);
    flags8("not", 1'b0, 1'b0, 1'b1);

    // Self-reference through forwarding
    cmd8(1'b1, 1'b1, 4'd11, 4'd0, 4'd0, 4'd0, 8'h21); cyc();
    cmd8(1'b0, 1'b1, 4'd11, 4'd11, 4'd11, 4'd0, 8'h00); cyc();
    chk("self1", {24'd0, res_data}, 32'h42);
    cmd8(1'b0, 1'b1, 4'd11, 4'd11, 4'd11, 4'd0, 8'h00); cyc();
    chk("self2", {24'd0, res_data}, 32'h84);
    cmd_valid = 1'b0; cyc();
    chk("idle_valid", {31'd0, res_valid}, 32'd0);

    // 16-bit instance: wrap-around add, then reset while stalled
    cmd16(1'b1, 1'b1, 3'd1, 3'd0, 3'd0, 4'd0, 16'hFFFF); cyc();
    cmd16(1'b1, 1'b1, 3'd2, 3'd0, 3'd0, 4'd0, 16'h0001); cyc();
    cmd16(1'b0, 1'b1, 3'd3, 3'd1, 3'd2, 4'd0, 16'h0000); cyc();
    chk("w16_add", {16'd0, res_data16}, 32'h0000);
    cmd16(1'b0, 1'b0, 3'd0, 3'd0, 3'd2, 4'd9, 16'h0000); cyc();
    chk("w16_passb", {16'd0, res_data16}, 32'h0001);
    chk("w16_c", {31'd0, flag_c16}, 32'd1);
    chk("w16_z", {31'd0, flag_z16}, 32'd1);
    res_ready16 = 1'b0;
    cmd16(1'b1, 1'b1, 3'd1, 3'd0, 3'd0, 4'd0, 16'h1234);
    cyc(); cyc();
    chk("w16_stall_data", {16'd0, res_data16}, 32'h0001);
    chk("w16_stall_ready", {31'd0, cmd_ready16}, 32'd0);
    cmd_valid16 = 1'b0;
    rst_n16 = 1'b0;
    #1;
    chk("w16_rst_valid", {31'd0, res_valid16}, 32'd0);
    chk("w16_rst_c", {31'd0, flag_c16}, 32'd0);
    @(negedge clk);
    rst_n16 = 1'b1; res_ready16 = 1'b1;
    cmd16(1'b0, 1'b0, 3'd0, 3'd1, 3'd3, 4'd3, 16'h0000); cyc();
    chk("w16_regs_clear", {16'd0, res_data16}, 32'h0000);
    chk("w16_post_z", {31'd0, flag_z16}, 32'd0);
    cmd_valid16 = 1'b0; cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
